switch_event_filter: RTL and testbench
======================================

// Module: switch_event_filter
// PURPOSE
//   Front end for one Go Board push-button; sits directly upstream of the mod-10 counter / 7-segment stage.
//   Synchronises and debounces the raw switch, then emits single-cycle press and release events.
//   Holding the switch produces auto-repeat step events.
//   The counter consumes o_Step_Pulse in place of its own edge detect: press = +1, held = repeated +1.
// PARAMETERS
//   DEBOUNCE_LIMIT  250000    cycles raw level must stay stable before o_Switch follows (10 ms @ 25 MHz); >=2
//   HOLD_LIMIT      12500000  cycles of debounced press before first repeat (500 ms); >=2
//   REPEAT_LIMIT    2500000   cycles between subsequent repeats (100 ms); >=2
// PORTS
//   i_Clk            in   1  system clock (25 MHz); single clock domain
//   i_Reset          in   1  asynchronous, active-high reset
//   i_Switch         in   1  raw switch pin, asynchronous, 1 = pressed
//   o_Switch         out  1  debounced level
//   o_Press_Pulse    out  1  1-cycle pulse, debounced 0->1
//   o_Release_Pulse  out  1  1-cycle pulse, debounced 1->0
//   o_Repeat_Pulse   out  1  1-cycle pulse per auto-repeat
//   o_Step_Pulse     out  1  o_Press_Pulse | o_Repeat_Pulse (registered)
//   o_Held           out  1  level, high while in REPEATING
// BEHAVIOUR
//   Reset (async assert, sync release): sync flops, debounce counter, hold counter = 0; state RELEASED; all outputs 0.
//   Sync: 2-flop synchroniser on i_Switch; only the second flop feeds the logic.
//   Debounce:
//     - counter increments each cycle while sync != o_Switch; cleared to 0 when equal.
//     - when it reaches DEBOUNCE_LIMIT-1 with mismatch still present: o_Switch <= sync, counter <= 0.
//     - latency: clean raw edge -> o_Switch changes 2+DEBOUNCE_LIMIT cycles later.
//     - any glitch shorter than DEBOUNCE_LIMIT cycles is invisible.
//   Pulses: all registered; asserted in exactly the cycle o_Switch first shows its new value (or the timer expires).
//   FSM (clocked on debounced level; 2-bit state):
//     - RELEASED : o_Switch rise -> PRESSED, press pulse, hold counter <= 0.
//     - PRESSED  : counter++; at HOLD_LIMIT-1 -> REPEATING, repeat pulse, counter <= 0.
//                  o_Switch fall -> RELEASED.
//     - REPEATING: counter++; at REPEAT_LIMIT-1 -> repeat pulse, counter <= 0.
//                  o_Switch fall -> RELEASED.
//     - Any state, o_Switch fall: release pulse, counter <= 0, o_Held <= 0.
//   Simultaneous events: release in the same cycle as timer expiry -> release wins; no repeat pulse.
//   Counters: widths $clog2(limit); saturating never needed (always cleared at terminal count).
//   Reset mid-hold: outputs drop immediately. After release, a still-pressed switch re-enters via a full debounce + press pulse.
//   Unused state encoding -> RELEASED on next clock.
// STRUCTURE
//   switch_event_defs.vh (shared include):
//     - state encodings ST_RELEASED/ST_PRESSED/ST_REPEATING
//     - 25 MHz default timing constants, reused by future multi-button tops.
//   Sub-module debounce_core (synchroniser + debounce counter; params DEBOUNCE_LIMIT; ports i_Clk, i_Reset, i_Switch, o_Switch).
//     Replaces the ad-hoc debounce filter for new designs.
//   Top of this file: debounce_core instance, edge detect, hold/repeat FSM, output registers.
// TESTING (bench params DEBOUNCE_LIMIT=4, HOLD_LIMIT=10, REPEAT_LIMIT=3)
//   1. Raw 0->1 clean, held 30 cycles
//        -> o_Switch rises 6 cycles after edge; 1 press pulse.
//        -> repeats at +10, +13, +16 ... cycles after press; o_Step_Pulse count = 1+repeats.
//   2. Raw toggles every 2 cycles for 20 cycles, then stays 1
//        -> no pulses during bounce; exactly one press pulse 6 cycles after settle.
//   3. Debounced press held 8 cycles, then release
//        -> 1 press, 1 release, 0 repeats; o_Held never high.
//   4. Release timed so o_Switch falls on the cycle the repeat counter hits 2 in REPEATING
//        -> release pulse, no repeat pulse, state RELEASED.
//   5. Single 3-cycle raw high glitch -> o_Switch and all pulses stay 0.
//   6. i_Reset asserted mid-REPEATING (async, between clocks)
//        -> all outputs 0 before next edge.
//        -> after deassert with switch still held, press pulse exactly 6 cycles later.

Source files
------------

// File: rtl/switch_event_filter_pkg.sv
// Shared definitions for the push-button event filter: state encodings,
// 25 MHz default timing constants and a small width helper.
package switch_event_filter_pkg;

  typedef enum logic [1:0] {
    ST_RELEASED  = 2'b00,
    ST_PRESSED   = 2'b01,
    ST_REPEATING = 2'b10
  } state_t;

  // 10 ms debounce, 500 ms before first repeat, 100 ms between repeats @ 25 MHz
  localparam int DEF_DEBOUNCE_LIMIT = 250000;
  localparam int DEF_HOLD_LIMIT     = 12500000;
  localparam int DEF_REPEAT_LIMIT   = 2500000;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/switch_event_filter_debounce_core.sv
// Two-flop synchroniser plus debounce counter for one raw switch pin.
// o_Commit is high in the cycle before o_Switch takes its new value, so the
// parent can register pulses that line up exactly with the o_Switch change.
module debounce_core
  import switch_event_filter_pkg::*;
#(
  parameter int DEBOUNCE_LIMIT = DEF_DEBOUNCE_LIMIT
) (
  input  logic i_Clk,
  input  logic i_Reset,
  input  logic i_Switch,
  output logic o_Switch,
  output logic o_Commit
);

  localparam int CW = $clog2(DEBOUNCE_LIMIT);

  logic          sync_meta;
  logic          sync_q;
  logic [CW-1:0] count;
  logic          mismatch;

  assign mismatch = (sync_q != o_Switch);
  assign o_Commit = mismatch && (count == CW'(DEBOUNCE_LIMIT - 1));

  // Synchronise the pin, then only accept a level that has differed from the
  // current debounced value for DEBOUNCE_LIMIT consecutive cycles.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      sync_meta <= 1'b0;
      sync_q    <= 1'b0;
      count     <= '0;
      o_Switch  <= 1'b0;
    end else begin
      sync_meta <= i_Switch;
      sync_q    <= sync_meta;
      if (o_Commit) begin
        o_Switch <= sync_q;
        count    <= '0;
      end else if (mismatch) begin
        count <= count + CW'(1);
      end else begin
        count <= '0;
      end
    end
  end

endmodule

// File: rtl/switch_event_filter.sv
// Push-button front end: debounce, press/release edge events and auto-repeat
// step events for the downstream counter.
//
//   state        | meaning
//   -------------+-----------------------------------------------------------
//   ST_RELEASED  | debounced switch low, waiting for a press
//   ST_PRESSED   | debounced high, counting towards the first repeat
//   ST_REPEATING | held past the hold time, repeat pulse every repeat period
//
// A debounced fall always wins over a timer expiry in the same cycle.
module switch_event_filter
  import switch_event_filter_pkg::*;
#(
  parameter int DEBOUNCE_LIMIT = DEF_DEBOUNCE_LIMIT,
  parameter int HOLD_LIMIT     = DEF_HOLD_LIMIT,
  parameter int REPEAT_LIMIT   = DEF_REPEAT_LIMIT
) (
  input  logic i_Clk,
  input  logic i_Reset,
  input  logic i_Switch,
  output logic o_Switch,
  output logic o_Press_Pulse,
  output logic o_Release_Pulse,
  output logic o_Repeat_Pulse,
  output logic o_Step_Pulse,
  output logic o_Held
);

  localparam int CNT_W = $clog2(max_int(HOLD_LIMIT, REPEAT_LIMIT));

  logic             commit;
  logic             rise;
  logic             fall;
  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             press_next;
  logic             release_next;
  logic             repeat_next;

  debounce_core #(
    .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)
  ) u_debounce (
    .i_Clk   (i_Clk),
    .i_Reset (i_Reset),
    .i_Switch(i_Switch),
    .o_Switch(o_Switch),
    .o_Commit(commit)
  );

  // Edge events are taken from the commit strobe so the registered pulses
  // appear in the same cycle o_Switch shows its new level.
  assign rise = commit & ~o_Switch;
  assign fall = commit &  o_Switch;

  // Next-state, hold/repeat timer and pulse decode.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    press_next   = 1'b0;
    release_next = 1'b0;
    repeat_next  = 1'b0;
    case (state)
      ST_RELEASED: begin
        cnt_next = '0;
        if (rise) begin
          state_next = ST_PRESSED;
          press_next = 1'b1;
        end
      end
      ST_PRESSED: begin
        if (cnt == CNT_W'(HOLD_LIMIT - 1)) begin
          state_next  = ST_REPEATING;
          repeat_next = 1'b1;
          cnt_next    = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      ST_REPEATING: begin
        if (cnt == CNT_W'(REPEAT_LIMIT - 1)) begin
          repeat_next = 1'b1;
          cnt_next    = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_next = ST_RELEASED;
        cnt_next   = '0;
      end
    endcase
    if (fall) begin
      state_next   = ST_RELEASED;
      cnt_next     = '0;
      release_next = 1'b1;
      repeat_next  = 1'b0;
      press_next   = 1'b0;
    end
  end

  // State, timer and registered event outputs.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state           <= ST_RELEASED;
      cnt             <= '0;
      o_Press_Pulse   <= 1'b0;
      o_Release_Pulse <= 1'b0;
      o_Repeat_Pulse  <= 1'b0;
      o_Step_Pulse    <= 1'b0;
      o_Held          <= 1'b0;
    end else begin
      state           <= state_next;
      cnt             <= cnt_next;
      o_Press_Pulse   <= press_next;
      o_Release_Pulse <= release_next;
      o_Repeat_Pulse  <= repeat_next;
      o_Step_Pulse    <= press_next | repeat_next;
      o_Held          <= (state_next == ST_REPEATING);
    end
  end

endmodule

// File: tb/tb_switch_event_filter.sv
// Directed bench for switch_event_filter with DEBOUNCE_LIMIT=4, HOLD_LIMIT=10,
// REPEAT_LIMIT=3. Outputs are packed as {sw, press, release, repeat, step, held}
// and compared once per cycle, 1 ns after the rising edge.
module tb_switch_event_filter;

  logic i_Clk = 1'b0;
  logic i_Reset = 1'b1;
  logic i_Switch = 1'b0;
  logic o_Switch, o_Press_Pulse, o_Release_Pulse, o_Repeat_Pulse, o_Step_Pulse, o_Held;

  int vectors = 0;
  int errors  = 0;

  switch_event_filter #(
    .DEBOUNCE_LIMIT(4),
    .HOLD_LIMIT    (10),
    .REPEAT_LIMIT  (3)
  ) dut (
    .i_Clk          (i_Clk),
    .i_Reset        (i_Reset),
    .i_Switch       (i_Switch),
    .o_Switch       (o_Switch),
    .o_Press_Pulse  (o_Press_Pulse),
    .o_Release_Pulse(o_Release_Pulse),
    .o_Repeat_Pulse (o_Repeat_Pulse),
    .o_Step_Pulse   (o_Step_Pulse),
    .o_Held         (o_Held)
  );

  always #5 i_Clk = ~i_Clk;

  wire [5:0] obs = {o_Switch, o_Press_Pulse, o_Release_Pulse, o_Repeat_Pulse, o_Step_Pulse, o_Held};

  task automatic step();
    @(posedge i_Clk);
    #1;
  endtask

  task automatic do_reset();
    i_Reset  = 1'b1;
    i_Switch = 1'b0;
    step();
    step();
    i_Reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int s = 1; s <= 4; s++) begin
      step();
      vectors++;
      if (obs !== 6'b000000) begin
        $display("FAIL reset_idle cyc=%0d got=%b want=000000", s, obs);
        errors++;
      end
    end
  endtask

  // Raw high before step 1, low before step 37: press at 6, repeats at
  // 16,19,...,40, release at 42.
  task automatic test_hold_repeat();
    logic [5:0] e;
    logic sw, pr, rl, rp, hd;
    int presses = 0;
    int steps = 0;
    do_reset();
    i_Switch = 1'b1;
    for (int s = 1; s <= 46; s++) begin
      step();
      if (s == 36) i_Switch = 1'b0;
      sw = (s >= 6) && (s < 42);
      pr = (s == 6);
      rl = (s == 42);
      rp = (s >= 16) && (s < 42) && (((s - 16) % 3) == 0);
      hd = (s >= 16) && (s < 42);
      e  = {sw, pr, rl, rp, pr | rp, hd};
      vectors++;
      if (obs !== e) begin
        $display("FAIL hold_repeat cyc=%0d got=%b want=%b", s, obs, e);
        errors++;
      end
      if (o_Press_Pulse) presses++;
      if (o_Step_Pulse) steps++;
    end
    vectors++;
    if (presses !== 1 || steps !== 10) begin
      $display("FAIL hold_repeat_counts press=%0d step=%0d want press=1 step=10", presses, steps);
      errors++;
    end
  endtask

  // Raw toggles every 2 cycles for 20 cycles, then settles high before step 21.
  task automatic test_bounce();
    logic [5:0] e;
    int presses = 0;
    do_reset();
    for (int s = 1; s <= 30; s++) begin
      i_Switch = (s - 1 < 20) ? ((((s - 1) / 2) % 2) == 0) : 1'b1;
      step();
      e = {(s >= 26), (s == 26), 1'b0, 1'b0, (s == 26), 1'b0};
      vectors++;
      if (obs !== e) begin
        $display("FAIL bounce cyc=%0d got=%b want=%b", s, obs, e);
        errors++;
      end
      if (o_Press_Pulse) presses++;
    end
    vectors++;
    if (presses !== 1) begin
      $display("FAIL bounce_press_count got=%0d want=1", presses);
      errors++;
    end
  endtask

  // Debounced high for cycles 6..13, release pulse at 14, no repeat.
  task automatic test_short_press();
    logic [5:0] e;
    do_reset();
    i_Switch = 1'b1;
    for (int s = 1; s <= 20; s++) begin
      if (s == 9) i_Switch = 1'b0;
      step();
      e = {(s >= 6) && (s < 14), (s == 6), (s == 14), 1'b0, (s == 6), 1'b0};
      vectors++;
      if (obs !== e) begin
        $display("FAIL short_press cyc=%0d got=%b want=%b", s, obs, e);
        errors++;
      end
    end
  endtask

  // o_Switch falls at 22, the cycle the third repeat would fire: release wins.
  task automatic test_release_vs_repeat();
    logic [5:0] e;
    logic rp;
    do_reset();
    i_Switch = 1'b1;
    for (int s = 1; s <= 28; s++) begin
      if (s == 17) i_Switch = 1'b0;
      step();
      rp = (s == 16) || (s == 19);
      e  = {(s >= 6) && (s < 22), (s == 6), (s == 22), rp, (s == 6) || rp, (s >= 16) && (s < 22)};
      vectors++;
      if (obs !== e) begin
        $display("FAIL release_vs_repeat cyc=%0d got=%b want=%b", s, obs, e);
        errors++;
      end
    end
  endtask

  // Raw high for exactly 3 cycles: nothing must get through.
  task automatic test_glitch();
    do_reset();
    for (int s = 1; s <= 14; s++) begin
      i_Switch = (s <= 3);
      step();
      vectors++;
      if (obs !== 6'b000000) begin
        $display("FAIL glitch cyc=%0d got=%b want=000000", s, obs);
        errors++;
      end
    end
  endtask

  // Async reset while repeating, then re-entry with switch still held.
  task automatic test_reset_mid_hold();
    logic [5:0] e;
    do_reset();
    i_Switch = 1'b1;
    for (int s = 1; s <= 20; s++) begin
      step();
    end
    vectors++;
    if (obs !== 6'b100001) begin
      $display("FAIL pre_reset_state got=%b want=100001", obs);
      errors++;
    end
    #3;
    i_Reset = 1'b1;
    #1;
    vectors++;
    if (obs !== 6'b000000) begin
      $display("FAIL async_reset got=%b want=000000", obs);
      errors++;
    end
    step();
    step();
    i_Reset = 1'b0;
    for (int s = 1; s <= 9; s++) begin
      step();
      e = {(s >= 6), (s == 6), 1'b0, 1'b0, (s == 6), 1'b0};
      vectors++;
      if (obs !== e) begin
        $display("FAIL reset_reentry cyc=%0d got=%b want=%b", s, obs, e);
        errors++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_hold_repeat();
    test_bounce();
    test_short_press();
    test_release_vs_repeat();
    test_glitch();
    test_reset_mid_hold();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
